rr_sel_arbiter_4: RTL and testbench

//  Round-robin arbiter that generates the 2-bit select (s1,s0) for the downstream 4:1 channel mux.
//  - Four requesters compete; exactly one is granted at a time.
//  - The grant is held until the consumer accepts (valid/ready handshake).
//  - Sits directly upstream of the mux: sel[1] drives s1, sel[0] drives s0.

---
 rtl/rr_arb_pkg.sv | 32 +++
 rtl/rr_pick_next.sv | 39 +++
 rtl/rr_sel_arbiter_4.sv | 153 +++++++++++++++
 tb/tb_rr_sel_arbiter_4.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// -----------------------------------------------------------------------------
// rr_arb_pkg
//   Shared constants, types and helpers for the 4-channel round-robin select
//   arbiter (rr_sel_arbiter_4) and its priority encoder (rr_pick_next).
//   - N_CH     : number of requesters
//   - SEL_W    : width of the binary select driving the downstream 4:1 mux
//   - BEAT_W   : width of the optional burst beat counter
//   - RST_LAST : "last served" value after reset, so ch0 wins first
//   - state_t  : arbiter FSM states
// -----------------------------------------------------------------------------
package rr_arb_pkg;

  localparam int N_CH   = 4;
  localparam int SEL_W  = 2;
  localparam int BEAT_W = 4;

  localparam logic [SEL_W-1:0] RST_LAST = 2'd3;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  // Binary channel index to one-hot grant vector.
  function automatic logic [N_CH-1:0] sel_to_onehot(input logic [SEL_W-1:0] s);
    logic [N_CH-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage : rr_arb_pkg

// File: rtl/rr_pick_next.sv
// -----------------------------------------------------------------------------
// rr_pick_next
//   Combinational rotate-priority encoder. Scans req starting at last+1 and
//   wrapping modulo N_CH, so the channel named by 'last' has lowest priority.
//   Ports:
//     req  in  N_CH   request vector
//     last in  SEL_W  most recently served channel
//     any  out 1      at least one request is set
//     idx  out SEL_W  index of the first set request in scan order
// -----------------------------------------------------------------------------
module rr_pick_next
  import rr_arb_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // NOTE: every signal written in a combinational block gets a default at the
  // top; otherwise a path that skips the assignment infers a latch.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    // Offsets 1..N_CH; the 2-bit add wraps 3->0 on its own, and offset N_CH
    // lands back on 'last' itself, which therefore comes last in the scan.
    for (int k = 1; k <= N_CH; k++) begin
      cand = last + SEL_W'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule : rr_pick_next

// File: rtl/rr_sel_arbiter_4.sv
// -----------------------------------------------------------------------------
// rr_sel_arbiter_4
//   Round-robin arbiter producing the 2-bit select {s1,s0} for a downstream
//   4:1 channel mux. One requester is granted at a time; the grant is held
//   until the consumer accepts it (valid && ready). All outputs are registered.
//   Ports:
//     clk    in   1  rising-edge clock
//     rst_n  in   1  asynchronous active-low reset
//     req    in   4  per-channel request, held high until its transfer is accepted
//     ready  in   1  consumer accepts the current muxed word this cycle
//     valid  out  1  sel/gnt are valid; a transfer occurs on valid && ready
//     sel    out  2  binary index of the granted channel (sel[1]->s1, sel[0]->s0)
//     gnt    out  4  one-hot grant, 1<<sel while valid, else 0
//   Parameter:
//     BURST_LEN      transfers per grant (1..15), used only with RR_BURST_EN
//   Configuration macro:
//     RR_BURST_EN    when defined, a beat counter keeps the grant on the same
//                    channel for up to BURST_LEN handshakes while its request
//                    stays high. When undefined, one transfer per grant.
// -----------------------------------------------------------------------------
module rr_sel_arbiter_4
  import rr_arb_pkg::*;
#(
  parameter int unsigned BURST_LEN = 4
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req,
  input  logic             ready,
  output logic             valid,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  gnt
);

  if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_burst_len_check
    $error("rr_sel_arbiter_4: BURST_LEN must be in 1..15");
  end

  state_t           state_q, state_d;
  logic             valid_d;
  logic [SEL_W-1:0] sel_d;
  logic [N_CH-1:0]  gnt_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic             rearb;

  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic [SEL_W-1:0] pick_last;

`ifdef RR_BURST_EN
  localparam logic [BEAT_W-1:0] BURST_LAST = BEAT_W'(BURST_LEN - 1);
  logic [BEAT_W-1:0] beat_q, beat_d;
`endif

  // While a grant is live the scan must start after the channel being served
  // right now (sel), which 'last' does not yet hold. In IDLE 'last' is current.
  assign pick_last = (state_q == GRANT) ? sel : last_q;

  rr_pick_next u_pick (
    .req  (req),
    .last (pick_last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    valid_d = valid;
    sel_d   = sel;
    gnt_d   = gnt;
    last_d  = last_q;
    rearb   = 1'b0;
`ifdef RR_BURST_EN
    beat_d  = beat_q;
`endif

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          valid_d = 1'b1;
          sel_d   = pick_idx;
          gnt_d   = sel_to_onehot(pick_idx);
        end
      end

      GRANT: begin
        // Without ready the grant simply holds, even if req[sel] dropped.
        if (ready) begin
          last_d = sel;
`ifdef RR_BURST_EN
          if (req[sel] && (beat_q < BURST_LAST)) begin
            beat_d = beat_q + 4'd1;
          end else begin
            beat_d = '0;
            rearb  = 1'b1;
          end
`else
          rearb = 1'b1;
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Re-arbitration on a handshake: load the next winner on the same edge
    // (no bubble) or fall back to IDLE. sel keeps its value while idle.
    if (rearb) begin
      if (pick_any) begin
        sel_d = pick_idx;
        gnt_d = sel_to_onehot(pick_idx);
      end else begin
        state_d = IDLE;
        valid_d = 1'b0;
        gnt_d   = '0;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register updates from
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid   <= 1'b0;
      sel     <= '0;
      gnt     <= '0;
      last_q  <= RST_LAST;
    end else begin
      state_q <= state_d;
      valid   <= valid_d;
      sel     <= sel_d;
      gnt     <= gnt_d;
      last_q  <= last_d;
    end
  end

`ifdef RR_BURST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end
`endif

endmodule : rr_sel_arbiter_4

// File: tb/tb_rr_sel_arbiter_4.sv
// -----------------------------------------------------------------------------
// tb_rr_sel_arbiter_4
//   Self-checking bench for rr_sel_arbiter_4. A transaction-level reference
//   model (last served channel, current grant, beats taken in this grant)
//   predicts valid/sel/gnt after every clock; directed sequences cover reset,
//   rotation, backpressure, fairness skip, single requester and async reset,
//   followed by randomized req/ready traffic.
// -----------------------------------------------------------------------------
module tb_rr_sel_arbiter_4;

`ifdef RR_BURST_EN
  localparam int BEATS = 4;
`else
  localparam int BEATS = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       ready;
  logic       valid;
  logic [1:0] sel;
  logic [3:0] gnt;

  int n_cmp;
  int n_bad;

  // Reference model state.
  bit m_valid;
  int m_sel;
  int m_last;
  int m_beats;

  rr_sel_arbiter_4 #(.BURST_LEN(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .ready (ready),
    .valid (valid),
    .sel   (sel),
    .gnt   (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // First requesting channel after 'from', wrapping round the four channels.
  function automatic int winner(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++) begin
      int ch;
      ch = (from + k) % 4;
      if (r[ch]) return ch;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_sel   = 0;
    m_last  = 3;
    m_beats = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic rd);
    int w;
    if (!m_valid) begin
      w = winner(r, m_last);
      if (w >= 0) begin
        m_valid = 1'b1;
        m_sel   = w;
        m_beats = 0;
      end
    end else if (rd) begin
      m_last = m_sel;
      if (r[m_sel] && (m_beats + 1 < BEATS)) begin
        m_beats++;
      end else begin
        m_beats = 0;
        w = winner(r, m_last);
        if (w >= 0) m_sel = w;
        else m_valid = 1'b0;
      end
    end
  endtask

  task automatic check_model(input string where);
    check({where, ".valid"}, 32'(valid), 32'(m_valid));
    check({where, ".sel"},   32'(sel),   32'(m_sel));
    check({where, ".gnt"},   32'(gnt),   m_valid ? (32'd1 << m_sel) : 32'd0);
  endtask

  // Apply inputs at the falling edge, advance the model across the next
  // rising edge, then compare 1 time unit after that edge.
  task automatic drive(input logic rst_v, input logic [3:0] r, input logic rd);
    @(negedge clk);
    rst_n = rst_v;
    req   = r;
    ready = rd;
    if (!rst_v) model_reset();
    else model_step(r, rd);
    @(posedge clk);
    #1;
    check_model("model");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    req   = 4'b1111;
    ready = 1'b0;
    rst_n = 1'b1;
    model_reset();

    // Reset with all requests up.
    #2 rst_n = 1'b0;
    #1;
    check("reset.valid", 32'(valid), 32'd0);
    check("reset.gnt",   32'(gnt),   32'd0);
    check("reset.sel",   32'(sel),   32'd0);
    drive(1'b0, 4'b1111, 1'b0);
    drive(1'b1, 4'b1111, 1'b0);
    check("first.sel", 32'(sel), 32'd0);
    check("first.gnt", 32'(gnt), 32'b0001);

    // Rotation with everyone requesting and ready high.
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 4'b1111, 1'b1);
      if (BEATS == 1) begin
        check("rot.sel",   32'(sel),   32'(i % 4));
        check("rot.valid", 32'(valid), 32'd1);
      end
    end
    drive(1'b1, 4'b0000, 1'b1);
    drive(1'b1, 4'b0000, 1'b1);
    check("drain.valid", 32'(valid), 32'd0);

    // Backpressure: grant to ch2 held while ready is low.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'b0100, 1'b0);
      check("bp.sel", 32'(sel), 32'd2);
      check("bp.gnt", 32'(gnt), 32'b0100);
    end
    drive(1'b1, 4'b0000, 1'b1);
    check("bp.idle", 32'(valid), 32'd0);

    // Fairness skip: serve ch1, then ch3 beats ch0 from last=1.
    drive(1'b1, 4'b0010, 1'b0);
    drive(1'b1, 4'b0000, 1'b1);
    drive(1'b1, 4'b1001, 1'b0);
    check("fair.sel3", 32'(sel), 32'd3);
    drive(1'b1, 4'b1001, 1'b1);
    if (BEATS == 1) check("fair.sel0", 32'(sel), 32'd0);
    drive(1'b1, 4'b0000, 1'b1);
    drive(1'b1, 4'b0000, 1'b1);

    // Single requester: granted on every ready cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'b1000, 1'b1);
      check("single.valid", 32'(valid), 32'd1);
      check("single.sel",   32'(sel),   32'd3);
    end

    // Asynchronous reset between edges while a grant is live.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("areset.valid", 32'(valid), 32'd0);
    check("areset.gnt",   32'(gnt),   32'd0);
    check("areset.sel",   32'(sel),   32'd0);
    drive(1'b0, 4'b1111, 1'b1);
    drive(1'b1, 4'b1111, 1'b0);
    check("areset.first", 32'(sel), 32'd0);

`ifdef RR_BURST_EN
    // Burst: ch0 keeps the grant for 4 beats, then ch1 takes over.
    drive(1'b0, 4'b0000, 1'b0);
    drive(1'b1, 4'b0011, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'b0011, 1'b1);
      check("burst.hold", 32'(sel), 32'd0);
    end
    drive(1'b1, 4'b0011, 1'b1);
    check("burst.next", 32'(sel), 32'd1);
    // ch0 requests again but ch1 drops after 2 beats: grant moves on early.
    drive(1'b1, 4'b0011, 1'b1);
    drive(1'b1, 4'b0001, 1'b1);
    check("burst.drop", 32'(sel), 32'd0);
`endif

    // Randomized traffic, including requests rising during a handshake and
    // protocol-violating drops, which the model treats as "grant held".
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] r;
      logic       rd;
      r  = 4'($urandom_range(0, 15));
      rd = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) r = 4'b0000;
      drive(1'b1, r, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_rr_sel_arbiter_4
